// File: rtl/ysyx_22050598_pkg.sv
// Shared IF/ID definitions: skid register state encoding and default datapath widths.
package ysyx_22050598_pkg;

  localparam int PC_W   = 64;
  localparam int INST_W = 32;

  typedef enum logic [1:0] {
    SKID_EMPTY = 2'd0,
    SKID_ONE   = 2'd1,
    SKID_TWO   = 2'd2
  } skid_state_e;

endpackage

// File: rtl/ysyx_22050598_dffr_async_en.sv
// Generic register with asynchronous active-high reset to RESET_VAL and a load enable.
module ysyx_22050598_dffr_async_en #(
  parameter int             DW        = 1,
  parameter logic [DW-1:0]  RESET_VAL = '0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic [DW-1:0] d,
  output logic [DW-1:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= RESET_VAL;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/ysyx_22050598_if_id_skid_reg.sv
// Two-entry IF/ID skid register: registered in_ready, 1-cycle latency, flush on redirect,
// saturating decode-stall counter.
module ysyx_22050598_if_id_skid_reg #(
  parameter int PC_W   = ysyx_22050598_pkg::PC_W,
  parameter int INST_W = ysyx_22050598_pkg::INST_W,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PC_W-1:0]   in_pc,
  input  logic [INST_W-1:0] in_inst,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PC_W-1:0]   out_pc,
  output logic [INST_W-1:0] out_inst,
  output logic [CNT_W-1:0]  stall_cnt
);

  import ysyx_22050598_pkg::*;

  localparam int PW = PC_W + INST_W;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  skid_state_e       state_reg, state_next;
  logic [1:0]        state_q;
  logic [PW-1:0]     main_reg, skid_reg, main_next, in_payload;
  logic              main_load, skid_load;
  logic              in_ready_reg, in_ready_next;
  logic              in_fire, out_fire;
  logic [CNT_W-1:0]  stall_cnt_reg, stall_cnt_next;
  logic              stall_inc;

  assign state_reg  = skid_state_e'(state_q);
  assign in_payload = {in_pc, in_inst};
  assign out_valid  = (state_reg != SKID_EMPTY);
  assign in_ready   = in_ready_reg;
  assign in_fire    = in_valid & in_ready_reg;
  assign out_fire   = out_valid & out_ready;

  always_comb begin
    state_next = state_reg;
    main_load  = 1'b0;
    skid_load  = 1'b0;
    main_next  = in_payload;
    case (state_reg)
      SKID_EMPTY: begin
        if (in_fire) begin
          state_next = SKID_ONE;
          main_load  = 1'b1;
        end
      end
      SKID_ONE: begin
        if (in_fire && out_fire) begin
          main_load = 1'b1;
        end else if (in_fire) begin
          state_next = SKID_TWO;
          skid_load  = 1'b1;
        end else if (out_fire) begin
          state_next = SKID_EMPTY;
        end
      end
      SKID_TWO: begin
        // in_ready is low here, so only the drain path can move the state.
        if (out_fire) begin
          state_next = SKID_ONE;
          main_load  = 1'b1;
          main_next  = skid_reg;
        end
      end
      default: state_next = SKID_EMPTY;
    endcase
    if (flush) begin
      state_next = SKID_EMPTY;
      main_load  = 1'b0;
      skid_load  = 1'b0;
    end
    in_ready_next = (state_next != SKID_TWO);
  end

  ysyx_22050598_dffr_async_en #(.DW(2), .RESET_VAL(2'(SKID_EMPTY))) u_state (
    .clk (clk), .rst (rst), .en (1'b1), .d (state_next), .q (state_q)
  );

  ysyx_22050598_dffr_async_en #(.DW(1), .RESET_VAL(1'b0)) u_in_ready (
    .clk (clk), .rst (rst), .en (1'b1), .d (in_ready_next), .q (in_ready_reg)
  );

  ysyx_22050598_dffr_async_en #(.DW(PW), .RESET_VAL('0)) u_main (
    .clk (clk), .rst (rst), .en (main_load), .d (main_next), .q (main_reg)
  );

  ysyx_22050598_dffr_async_en #(.DW(PW), .RESET_VAL('0)) u_skid (
    .clk (clk), .rst (rst), .en (skid_load), .d (in_payload), .q (skid_reg)
  );

  assign out_pc   = main_reg[PW-1:INST_W];
  assign out_inst = main_reg[INST_W-1:0];

  assign stall_inc      = out_valid & ~out_ready & ~flush & (stall_cnt_reg != CNT_MAX);
  assign stall_cnt_next = stall_cnt_reg + CNT_W'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_reg <= '0;
    end else if (stall_inc) begin
      stall_cnt_reg <= stall_cnt_next;
    end
  end

  assign stall_cnt = stall_cnt_reg;

endmodule

// File: tb/tb_ysyx_22050598_if_id_skid_reg.sv
// Scoreboard bench for the IF/ID skid register: queue-based occupancy model, directed and random traffic.
module tb_ysyx_22050598_if_id_skid_reg;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] inst;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [63:0] in_pc = '0;
  logic [31:0] in_inst = '0;

  logic        in_ready, out_valid;
  logic [63:0] out_pc;
  logic [31:0] out_inst;
  logic [31:0] stall_cnt;

  logic        in_ready_s, out_valid_s;
  logic [63:0] out_pc_s;
  logic [31:0] out_inst_s;
  logic [3:0]  stall_cnt_s;

  ysyx_22050598_if_id_skid_reg #(.PC_W(64), .INST_W(32), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_inst(in_inst),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_inst(out_inst),
    .stall_cnt(stall_cnt)
  );

  ysyx_22050598_if_id_skid_reg #(.PC_W(64), .INST_W(32), .CNT_W(4)) dut_sat (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready_s), .in_pc(in_pc), .in_inst(in_inst),
    .out_valid(out_valid_s), .out_ready(out_ready), .out_pc(out_pc_s), .out_inst(out_inst_s),
    .stall_cnt(stall_cnt_s)
  );

  always #5 clk = ~clk;

  ent_t        exp_q[$];
  ent_t        head;
  logic        model_ready;
  logic        model_valid;
  logic [31:0] model_cnt;
  logic [3:0]  model_cnt_s;
  bit          last_accept;
  int          n_tests = 0;
  int          n_fail  = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic reset_model();
    exp_q.delete();
    model_ready = 1'b0;
    model_valid = 1'b0;
    model_cnt   = '0;
    model_cnt_s = '0;
    last_accept = 1'b0;
  endtask

  // Advance the reference model across one rising edge using the inputs held through it.
  task automatic model_step();
    last_accept = 1'b0;
    if (rst) begin
      reset_model();
      return;
    end
    if (model_valid && !out_ready && !flush) begin
      if (model_cnt != 32'hFFFF_FFFF) model_cnt = model_cnt + 1;
      if (model_cnt_s != 4'hF) model_cnt_s = model_cnt_s + 1;
    end
    if (flush) begin
      exp_q.delete();
    end else if (in_valid && model_ready) begin
      exp_q.push_back({in_pc, in_inst});
      last_accept = 1'b1;
    end
    model_ready = (exp_q.size() < 2);
    model_valid = (exp_q.size() != 0);
  endtask

  // Monitor: compares presented outputs to the model, pops on every decode acceptance.
  always @(negedge clk) begin
    if (!rst) begin
      check("out_valid", out_valid, exp_q.size() != 0);
      check("in_ready", in_ready, model_ready);
      check("stall_cnt", stall_cnt, model_cnt);
      check("stall_cnt_w4", stall_cnt_s, model_cnt_s);
      check("w4_valid_ready", {out_valid_s, in_ready_s}, {exp_q.size() != 0, model_ready});
      if (exp_q.size() != 0) begin
        head = exp_q[0];
        check("out_pc", out_pc, head.pc);
        check("out_inst", out_inst, head.inst);
        check("w4_out_pc", out_pc_s, head.pc);
        check("w4_out_inst", out_inst_s, head.inst);
        if (out_ready) void'(exp_q.pop_front());
      end
    end
  end

  task automatic cycle(input logic iv, input logic [63:0] pc, input logic ordy, input logic fl);
    in_valid  = iv;
    in_pc     = pc;
    in_inst   = $urandom;
    out_ready = ordy;
    flush     = fl;
    @(posedge clk);
    model_step();
    #1;
  endtask

  // Fetch-side behaviour: present pc until it is taken.
  task automatic send(input logic [63:0] pc, input logic ordy);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      cycle(1'b1, pc, ordy, 1'b0);
      ok = last_accept;
    end
    check("send_accept", ok, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_model();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_in_ready", in_ready, 1'b0);
    check("rst_stall_cnt", stall_cnt, 32'd0);
    rst = 1'b0;
    #1;
    check("rel_in_ready_low", in_ready, 1'b0);
    cycle(1'b0, 64'd0, 1'b0, 1'b0);
    check("rel_in_ready_high", in_ready, 1'b1);

    // Stall counting and saturation of the 4-bit instance.
    send(64'h300, 1'b0);
    repeat (5) cycle(1'b0, 64'd0, 1'b0, 1'b0);
    check("stall_5", stall_cnt, 32'd5);
    repeat (15) cycle(1'b0, 64'd0, 1'b0, 1'b0);
    check("stall_20", stall_cnt, 32'd20);
    check("stall_sat", stall_cnt_s, 4'hF);
    cycle(1'b0, 64'd0, 1'b1, 1'b0);

    // Back-to-back streaming.
    send(64'h8000_0000, 1'b1);
    send(64'h8000_0004, 1'b1);
    send(64'h8000_0008, 1'b1);
    repeat (2) cycle(1'b0, 64'd0, 1'b1, 1'b0);

    // Fill both entries, third held off, then drain in order.
    send(64'h100, 1'b0);
    send(64'h104, 1'b0);
    repeat (2) cycle(1'b1, 64'h108, 1'b0, 1'b0);
    check("two_in_ready", in_ready, 1'b0);
    check("two_out_pc", out_pc, 64'h100);
    send(64'h108, 1'b1);
    repeat (3) cycle(1'b0, 64'd0, 1'b1, 1'b0);

    // Flush while full, with a fetch offered in the same cycle.
    send(64'h180, 1'b0);
    send(64'h184, 1'b0);
    cycle(1'b1, 64'h200, 1'b0, 1'b1);
    check("flush_out_valid", out_valid, 1'b0);
    check("flush_in_ready", in_ready, 1'b1);
    repeat (2) cycle(1'b0, 64'd0, 1'b1, 1'b0);

    // Randomized traffic.
    repeat (400) begin
      cycle(($urandom_range(0, 9) < 7), {32'h8000_0000, 30'($urandom), 2'b00},
            ($urandom_range(0, 9) < 6), ($urandom_range(0, 19) == 0));
    end
    repeat (3) cycle(1'b0, 64'd0, 1'b1, 1'b0);

    // Asynchronous reset mid-cycle while full.
    send(64'h400, 1'b0);
    send(64'h404, 1'b0);
    #2 rst = 1'b1;
    #1;
    check("async_rst_out_valid", out_valid, 1'b0);
    check("async_rst_in_ready", in_ready, 1'b0);
    check("async_rst_stall", stall_cnt, 32'd0);
    reset_model();
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) cycle(1'b0, 64'd0, 1'b1, 1'b0);
    send(64'h500, 1'b1);
    repeat (2) cycle(1'b0, 64'd0, 1'b1, 1'b0);
    check("end_queue_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
